ahb_lite_accel_port: RTL and testbench
======================================

# ahb_lite_accel_port

AHB-Lite slave that connects a streaming arithmetic accelerator (CORDIC or similar) to the system bus. It is the parametrised successor of the single-register CORDIC bridge. It adds:
- a built-in result FIFO of configurable depth;
- proper AHB address/data-phase pipelining;
- wait states on operand back-pressure and on reads of an empty FIFO, with a timeout that produces an ERROR response;
- a status/control register pair.

It sits between the AHB-Lite interconnect and one accelerator instance.

## Interface
Parameters:
- DATA_W, 32, operand/result width, 1..32; bus data is zero-extended on reads and truncated to the low DATA_W bits on writes.
- FIFO_DEPTH, 8, result FIFO entries, power of two, 2..64.
- WAIT_MAX, 16, maximum stall cycles on a blocking read of an empty FIFO before the ERROR response, 1..255.

Ports:
- HCLK in 1: single clock; all logic is rising-edge.
- HRESETn in 1: reset, synchronous, active-low.
- HSEL in 1: slave select.
- HADDR in 32: only HADDR[3:2] is decoded.
- HTRANS in 2: transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE in 1: 1 = write, 0 = read.
- HSIZE in 3: ignored; all accesses are treated as word accesses.
- HREADY in 1: bus ready.
- HWDATA in 32: write data.
- HREADYOUT out 1: transfer-done / stall.
- HRESP out 2: 2'b00 OKAY, 2'b01 ERROR.
- HRDATA out 32: read data.
- acc_data_in out DATA_W: operand to the accelerator.
- acc_valid_in out 1: operand valid.
- acc_ready_in in 1: accelerator accepts the operand.
- acc_data_out in DATA_W: accelerator result.
- acc_valid_out in 1: result valid, single-cycle per result; the accelerator has no back-pressure.

## Operation
Register map (HADDR[3:2]):
- 0 DATA: write pushes an operand to the accelerator; read pops the FIFO head.
- 1 STATUS (RO): [0] empty, [1] full, [2] sticky overflow, [15:8] count.
- 2 CTRL (RW): [0] flush (write-1 pulse, reads 0), [1] blocking-read enable, [2] write-1 clears overflow.
- 3: reads 0, writes ignored, OKAY.

Address phase:
- A transfer is accepted when HSEL & HREADY & HTRANS[1].
- HADDR[3:2] and HWRITE are registered at acceptance; the data phase is the following cycle(s).

FSM states and transitions:
- IDLE: no data phase pending.
- WR_DATA: the operand is driven while acc_valid_in=1. If acc_ready_in=0, HREADYOUT=0 and the operand is held. The transfer completes in the cycle acc_ready_in=1.
- RD_DATA:
  - FIFO non-empty: HRDATA is the head, HREADYOUT=1, and the pop happens at completion.
  - Empty with CTRL[1]=1: HREADYOUT=0 and the wait counter increments. Completion occurs as soon as a result arrives, and the result is forwarded in the same cycle it is written (bypass). When the counter reaches WAIT_MAX, go to ERR1.
  - Empty with CTRL[1]=0: HRDATA=0, OKAY, completes immediately.
- REG: STATUS/CTRL/unused accesses complete in one cycle with no wait states.
- ERR1: HRESP=01, HREADYOUT=0. Always followed by ERR2.
- ERR2: HRESP=01, HREADYOUT=1. Nothing is popped.
- A back-to-back accepted transfer moves directly to its data-phase state; otherwise the FSM returns to IDLE.

FIFO:
- Push when acc_valid_out=1.
- A push while full (with no pop in the same cycle) drops the result and sets overflow.
- Simultaneous push and pop is always legal; count is unchanged.
- Flush empties the FIFO the cycle after the CTRL write completes. A push in the flush cycle is discarded.
- Pointer width is log2(FIFO_DEPTH)+1; pointers wrap modulo 2·FIFO_DEPTH.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=00, HRDATA=0;
  - acc_valid_in=0, acc_data_in=0;
  - FIFO empty, overflow=0;
  - CTRL[1]=1;
  - FSM in IDLE, wait counter 0.
- Reset asserted mid-transfer aborts the data phase. In the next cycle all outputs are at reset values and FIFO contents are lost.
- Zero-wait latencies:
  - DATA write: 1 data-phase cycle when acc_ready_in=1 is already high.
  - Non-empty read: 1 data-phase cycle.
- acc_data_in and acc_valid_in are driven only in WR_DATA; in all other states they are 0.
- HRDATA is valid only in completing read cycles; it is 0 otherwise.
- STATUS reflects the registered FIFO state at the start of the data-phase cycle.

## Test plan
- Reset, then read STATUS -> 0x0000_0001, OKAY, zero wait states.
- Write DATA 0x1234_5678 with acc_ready_in held low 3 cycles -> HREADYOUT low for 3 cycles, acc_valid_in high for 4 cycles, acc_data_in=0x1234_5678 throughout, OKAY.
- Push 3 results (0xA, 0xB, 0xC), then 3 back-to-back DATA reads -> HRDATA 0xA, 0xB, 0xC with no wait states; STATUS then reads 0x0000_0001.
- Blocking read on empty FIFO:
  - result 0x55 arrives after 5 stall cycles -> completion in that cycle with HRDATA=0x55, FIFO stays empty;
  - no result arrives (WAIT_MAX=16) -> 16 stall cycles, then ERR1 and ERR2 with HRESP=01, then IDLE.
- Push FIFO_DEPTH+1 results with no reads -> STATUS count=8, full=1, overflow=1; write CTRL=0x5 -> STATUS 0x0000_0001.
- With the FIFO full, pop and push in the same cycle -> count stays 8, no overflow. Write CTRL=0x0, then read DATA on an empty FIFO -> 0, OKAY, no stall.

Source files
------------

// File: rtl/ahb_lite_accel_port.sv
// AHB-Lite slave bridging the system bus to one streaming accelerator, with a result FIFO.
// Latency: one data-phase cycle for register accesses, DATA writes with ready high, and non-empty DATA reads.
// Backpressure: waits on acc_ready_in and on blocking reads of an empty FIFO. A blocking read that sees no result for WAIT_MAX cycles ends with an ERROR response.
//
// Ports:
//   HCLK, HRESETn          clock and synchronous active-low reset
//   HSEL..HWDATA           AHB-Lite slave inputs (only HADDR[3:2] is decoded; HSIZE is ignored)
//   HREADYOUT/HRESP/HRDATA AHB-Lite slave response
//   acc_data_in/acc_valid_in/acc_ready_in   operand stream to the accelerator
//   acc_data_out/acc_valid_out              result stream from the accelerator (no back-pressure)
module ahb_lite_accel_port #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int WAIT_MAX   = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic [DATA_W-1:0] acc_data_in,
  output logic              acc_valid_in,
  input  logic              acc_ready_in,
  input  logic [DATA_W-1:0] acc_data_out,
  input  logic              acc_valid_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_REG, S_ERR1, S_ERR2} state_t;

  state_t            r_state, w_next, w_target;
  logic [1:0]        r_addr;
  logic              r_write;
  logic [7:0]        r_wait;
  logic              r_blk;
  logic              r_ovf;
  logic [AW:0]       r_wptr, r_rptr;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic              w_accept, w_empty, w_full, w_pop, w_push, w_drop, w_bypass;
  logic              w_wait_inc, w_ctrl_wr, w_flush;
  logic [AW:0]       w_count;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA};

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_target = (HADDR[3:2] != 2'd0) ? S_REG : (HWRITE ? S_WR : S_RD);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count = r_wptr - r_rptr;

  // A flush takes effect on the edge that completes the CTRL write, so any
  // result arriving in that same cycle is discarded along with the contents.
  assign w_flush = w_ctrl_wr & HWDATA[0];
  // A result consumed by the bypass path goes straight to the bus, never into the FIFO.
  assign w_push  = acc_valid_out & ~w_bypass & ~w_flush & (~w_full | w_pop);
  assign w_drop  = acc_valid_out & ~w_bypass & ~w_flush & w_full & ~w_pop;

  always_comb begin
    w_next       = r_state;
    HREADYOUT    = 1'b1;
    HRESP        = 2'b00;
    w_rdata      = '0;
    acc_valid_in = 1'b0;
    acc_data_in  = '0;
    w_pop        = 1'b0;
    w_bypass     = 1'b0;
    w_wait_inc   = 1'b0;
    w_ctrl_wr    = 1'b0;
    case (r_state)
      S_WR: begin
        acc_valid_in = 1'b1;
        acc_data_in  = HWDATA[DATA_W-1:0];
        HREADYOUT    = acc_ready_in;
      end
      S_RD: begin
        if (!w_empty) begin
          w_rdata[DATA_W-1:0] = r_mem[r_rptr[AW-1:0]];
          w_pop               = 1'b1;
        end else if (r_blk) begin
          if (acc_valid_out) begin
            w_rdata[DATA_W-1:0] = acc_data_out;
            w_bypass            = 1'b1;
          end else begin
            HREADYOUT  = 1'b0;
            w_wait_inc = 1'b1;
            if (r_wait == 8'(WAIT_MAX - 1)) w_next = S_ERR1;
          end
        end
      end
      S_REG: begin
        if (r_write) begin
          w_ctrl_wr = (r_addr == 2'd2);
        end else if (r_addr == 2'd1) begin
          w_rdata[0]         = w_empty;
          w_rdata[1]         = w_full;
          w_rdata[2]         = r_ovf;
          w_rdata[8 +: AW+1] = w_count;
        end else if (r_addr == 2'd2) begin
          w_rdata[1] = r_blk;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        w_next    = S_ERR2;
      end
      S_ERR2: begin
        HRESP = 2'b01;
      end
      default: ;
    endcase
    // Every completing data phase either chains straight into the next
    // accepted transfer or falls back to IDLE.
    if (HREADYOUT) w_next = w_accept ? w_target : S_IDLE;
    HRDATA = w_rdata;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_addr  <= 2'd0;
      r_write <= 1'b0;
      r_wait  <= 8'd0;
      r_blk   <= 1'b1;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= HADDR[3:2];
        r_write <= HWRITE;
      end
      r_wait <= w_wait_inc ? r_wait + 8'd1 : 8'd0;
      if (w_ctrl_wr) r_blk <= HWDATA[1];
      if (w_drop) r_ovf <= 1'b1;
      else if (w_ctrl_wr && HWDATA[2]) r_ovf <= 1'b0;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= acc_data_out;
  end

endmodule

// File: tb/tb_ahb_lite_accel_port.sv
module tb_ahb_lite_accel_port;

  logic        clk, rst_n;
  logic        hsel, hwrite, hreadyout;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize;
  logic [31:0] acc_data_in, acc_data_out;
  logic        acc_valid_in, acc_ready_in, acc_valid_out;

  int total = 0;
  int bad   = 0;

  ahb_lite_accel_port #(.DATA_W(32), .FIFO_DEPTH(8), .WAIT_MAX(16)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hreadyout), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .acc_data_in(acc_data_in), .acc_valid_in(acc_valid_in), .acc_ready_in(acc_ready_in),
    .acc_data_out(acc_data_out), .acc_valid_out(acc_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [1:0] a);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = {28'h0, a, 2'b00};
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  // Single transfer; entered and left at posedge+1.
  task automatic xfer(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rs, output int stalls);
    addr_phase(wr, a);
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    stalls = 0;
    @(negedge clk);
    while (!hreadyout && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    rd = hrdata;
    rs = hresp;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d);
    acc_valid_out = 1'b1; acc_data_out = d;
    @(posedge clk); #1;
    acc_valid_out = 1'b0; acc_data_out = '0;
  endtask

  task automatic reg_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic [1:0] rs; int st;
    xfer(1'b0, a, 32'h0, rd, rs, st);
    check({name, "_data"}, rd, exp);
    check({name, "_stalls"}, st, 0);
  endtask

  task automatic reg_wr(input string name, input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic [1:0] rs; int st;
    xfer(1'b1, a, wd, rd, rs, st);
    check({name, "_resp"}, {30'h0, rs}, 0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] rd;
  logic [1:0]  rs;
  int          st, vcnt, dbad, n;
  logic        done;

  initial begin
    tbl[0]  = '{1'b0, 2'd1, 32'h0,        32'h1};  // STATUS after reset: empty
    tbl[1]  = '{1'b0, 2'd2, 32'h0,        32'h2};  // CTRL after reset: blocking on
    tbl[2]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    tbl[4]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 2'd2, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,        32'h0};  // non-blocking read of empty FIFO
    tbl[8]  = '{1'b1, 2'd2, 32'h2,        32'h0};
    tbl[9]  = '{1'b0, 2'd2, 32'h0,        32'h2};
    tbl[10] = '{1'b0, 2'd1, 32'h0,        32'h1};

    rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
    hsize = 3'b010; acc_ready_in = 1'b1; acc_valid_out = 1'b0; acc_data_out = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hreadyout", {31'h0, hreadyout}, 1);
    check("rst_hresp", {30'h0, hresp}, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_acc_valid_in", {31'h0, acc_valid_in}, 0);
    check("rst_acc_data_in", acc_data_in, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, rs, st);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_resp", i), {30'h0, rs}, 0);
      check($sformatf("vec%0d_stalls", i), st, 0);
    end

    // Operand write held off by acc_ready_in for three cycles.
    addr_phase(1'b1, 2'd0);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h12345678;
    st = 0; vcnt = 0; dbad = 0; done = 1'b0; rs = 2'b11;
    for (int c = 0; c < 20 && !done; c++) begin
      acc_ready_in = (c >= 3);
      @(negedge clk);
      if (acc_valid_in) begin
        vcnt++;
        if (acc_data_in !== 32'h12345678) dbad++;
      end
      if (hreadyout) begin
        done = 1'b1;
        rs = hresp;
      end else st++;
      @(posedge clk); #1;
    end
    check("wr_stalls", st, 3);
    check("wr_valid_cycles", vcnt, 4);
    check("wr_data_hold_errs", dbad, 0);
    check("wr_resp", {30'h0, rs}, 0);
    @(negedge clk);
    check("wr_valid_after", {31'h0, acc_valid_in}, 0);
    @(posedge clk); #1;

    // Three results, then three pipelined reads.
    push(32'hA); push(32'hB); push(32'hC);
    addr_phase(1'b0, 2'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) addr_phase(1'b0, 2'd0); else bus_idle();
      @(negedge clk);
      check($sformatf("b2b%0d_ready", i), {31'h0, hreadyout}, 1);
      check($sformatf("b2b%0d_rdata", i), hrdata, 32'hA + i);
      @(posedge clk); #1;
    end
    reg_rd("b2b_status", 2'd1, 32'h1);

    // Blocking read, result arrives after five stalls and is bypassed.
    addr_phase(1'b0, 2'd0);
    @(posedge clk); #1;
    bus_idle();
    st = 0; done = 1'b0; rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == 5) begin acc_valid_out = 1'b1; acc_data_out = 32'h55; end
      @(negedge clk);
      if (hreadyout) begin done = 1'b1; rd = hrdata; rs = hresp; end
      else st++;
      @(posedge clk); #1;
      acc_valid_out = 1'b0; acc_data_out = '0;
    end
    check("byp_stalls", st, 5);
    check("byp_rdata", rd, 32'h55);
    check("byp_resp", {30'h0, rs}, 0);
    reg_rd("byp_status", 2'd1, 32'h1);

    // Blocking read, no result: timeout then two-cycle ERROR.
    addr_phase(1'b0, 2'd0);
    @(posedge clk); #1;
    bus_idle();
    n = 0;
    @(negedge clk);
    while (!hreadyout && hresp == 2'b00 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_stalls", n, 16);
    check("to_err1", {29'h0, hreadyout, hresp}, 32'h1);
    @(negedge clk);
    check("to_err2", {29'h0, hreadyout, hresp}, 32'h5);
    @(negedge clk);
    check("to_idle", {29'h0, hreadyout, hresp}, 32'h4);
    @(posedge clk); #1;

    // Overflow: nine results into eight entries.
    for (int i = 0; i < 9; i++) push(32'h100 + i);
    reg_rd("ovf_status", 2'd1, 32'h0806);
    reg_wr("ovf_ctrl", 2'd2, 32'h5);
    reg_rd("ovf_status_clr", 2'd1, 32'h1);

    // Full FIFO: pop and push in the same cycle.
    for (int i = 0; i < 8; i++) push(32'h200 + i);
    reg_rd("full_status", 2'd1, 32'h0802);
    addr_phase(1'b0, 2'd0);
    @(posedge clk); #1;
    bus_idle();
    acc_valid_out = 1'b1; acc_data_out = 32'h2FF;
    @(negedge clk);
    check("pp_ready", {31'h0, hreadyout}, 1);
    check("pp_rdata", hrdata, 32'h200);
    @(posedge clk); #1;
    acc_valid_out = 1'b0; acc_data_out = '0;
    reg_rd("pp_status", 2'd1, 32'h0802);
    reg_rd("pp_next", 2'd0, 32'h201);
    reg_rd("pp_status2", 2'd1, 32'h0700);
    reg_wr("flush_ctrl", 2'd2, 32'h1);
    reg_rd("flush_status", 2'd1, 32'h1);
    xfer(1'b0, 2'd0, 32'h0, rd, rs, st);
    check("nb_rdata", rd, 0);
    check("nb_resp", {30'h0, rs}, 0);
    check("nb_stalls", st, 0);

    // Reset during a stalled operand write.
    push(32'h77);
    acc_ready_in = 1'b0;
    addr_phase(1'b1, 2'd0);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hDEAD;
    @(negedge clk);
    check("mid_valid", {31'h0, acc_valid_in}, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {hreadyout, hresp, acc_valid_in}, 4'b1000);
    check("mid_rst_hrdata", hrdata, 0);
    check("mid_rst_data_in", acc_data_in, 0);
    @(posedge clk); #1;
    acc_ready_in = 1'b1;
    reg_rd("mid_status", 2'd1, 32'h1);
    reg_rd("mid_ctrl", 2'd2, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
